// File: rtl/adder_arbiter.sv
// Round-robin share of one W-bit adder between two requesters; result valid 2 cycles after the request handshake.
// One op in flight at a time; a stalled response holds the block in RESP and blocks all new grants.
module adder_arbiter #(
   parameter int W     = 6,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [W-1:0]     req0_x,
   input  logic [W-1:0]     req0_y,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [W-1:0]     req1_x,
   input  logic [W-1:0]     req1_y,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [W-1:0]     resp0_sum,
   output logic             resp0_ov,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [W-1:0]     resp1_sum,
   output logic             resp1_ov,
   output logic [CNT_W-1:0] ov_count,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t         state, state_nxt;
   logic           ptr;
   logic           g;
   logic [W-1:0]   x_r, y_r;
   logic [W-1:0]   sum_r;
   logic           ov_r;
   logic           gnt;
   logic           hs;
   logic           resp_hs;
   logic [W-1:0]   add_sum;
   logic           add_ov;

   // ptr only matters when both requesters compete
   assign gnt = req1_valid & (~req0_valid | ptr);

   assign req0_ready = rst_n & (state == IDLE) & req0_valid & ~gnt;
   assign req1_ready = rst_n & (state == IDLE) & req1_valid & gnt;
   assign hs         = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign resp_hs    = g ? resp1_ready : resp0_ready;

   assign {add_ov, add_sum} = {1'b0, x_r} + {1'b0, y_r};

   assign resp0_valid = (state == RESP) & ~g;
   assign resp1_valid = (state == RESP) & g;
   assign resp0_sum   = sum_r;
   assign resp1_sum   = sum_r;
   assign resp0_ov    = ov_r;
   assign resp1_ov    = ov_r;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = CALC;
         CALC:    state_nxt = RESP;
         RESP:    if (resp_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr      <= 1'b0;
         g        <= 1'b0;
         x_r      <= '0;
         y_r      <= '0;
         sum_r    <= '0;
         ov_r     <= 1'b0;
         ov_count <= '0;
      end else begin
         case (state)
            IDLE: if (hs) begin
               g   <= gnt;
               x_r <= gnt ? req1_x : req0_x;
               y_r <= gnt ? req1_y : req0_y;
            end
            CALC: begin
               sum_r <= add_sum;
               ov_r  <= add_ov;
               if (add_ov && (ov_count != '1)) ov_count <= ov_count + CNT_W'(1);
            end
            RESP: if (resp_hs) ptr <= ~g;
            default: ;
         endcase
      end
   end

endmodule
